// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that funnels per-processor read/write
// requests onto one memory port and broadcasts read data back to the pool.
// Optional read timeout: define MEM_ARB_RD_TIMEOUT_EN to enable it.

// Per-processor lane: slices the flat request buses into one processor's view.
module mem_arbiter_lane #(
  parameter int BUS_W  = 64,
  parameter int ADDR_W = 16
) (
  input  logic              i_req_rd,
  input  logic              i_req_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [BUS_W-1:0]  i_wr_data,
  input  logic [2:0]        i_wr_size,
  output logic              o_req,
  output logic [ADDR_W-1:0] o_addr,
  output logic [BUS_W-1:0]  o_wr_data,
  output logic [2:0]        o_wr_size
);
  assign o_req     = i_req_rd | i_req_wr;
  assign o_addr    = i_addr;
  assign o_wr_data = i_wr_data;
  assign o_wr_size = i_wr_size;
endmodule

module mem_arbiter #(
  parameter int PROC_COUNT = 4,
  parameter int BUS_W      = 64,
  parameter int ADDR_W     = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic [PROC_COUNT-1:0]        i_req_rd,
  input  logic [PROC_COUNT-1:0]        i_req_wr,
  input  logic [PROC_COUNT*ADDR_W-1:0] i_addr,
  input  logic [PROC_COUNT*BUS_W-1:0]  i_wr_data,
  input  logic [PROC_COUNT*3-1:0]      i_wr_size,
  output logic [PROC_COUNT-1:0]        o_grant_rd,
  output logic [PROC_COUNT-1:0]        o_grant_wr,
  output logic [PROC_COUNT-1:0]        o_valid,
  output logic [BUS_W-1:0]             o_data,
  output logic                         o_mem_en,
  output logic                         o_mem_we,
  output logic [ADDR_W-1:0]            o_mem_addr,
  output logic [BUS_W-1:0]             o_mem_wdata,
  output logic [2:0]                   o_mem_wsize,
  input  logic [BUS_W-1:0]             i_mem_rdata,
  input  logic                         i_mem_rvalid,
  output logic                         o_err
);

  localparam int PW = (PROC_COUNT > 1) ? $clog2(PROC_COUNT) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, RD_WAIT} state_t;

  state_t                              state;
  logic [PW-1:0]                       ptr;
  logic [PW-1:0]                       w;
  logic                                cur_we;
  logic [PW-1:0]                       win;
  logic [PROC_COUNT-1:0]               req;
  logic [PROC_COUNT-1:0][ADDR_W-1:0]   addr_a;
  logic [PROC_COUNT-1:0][BUS_W-1:0]    wdata_a;
  logic [PROC_COUNT-1:0][2:0]          wsize_a;

  for (genvar g = 0; g < PROC_COUNT; g++) begin : g_lane
    mem_arbiter_lane #(.BUS_W(BUS_W), .ADDR_W(ADDR_W)) u_lane (
      .i_req_rd  (i_req_rd[g]),
      .i_req_wr  (i_req_wr[g]),
      .i_addr    (i_addr[g*ADDR_W +: ADDR_W]),
      .i_wr_data (i_wr_data[g*BUS_W +: BUS_W]),
      .i_wr_size (i_wr_size[g*3 +: 3]),
      .o_req     (req[g]),
      .o_addr    (addr_a[g]),
      .o_wr_data (wdata_a[g]),
      .o_wr_size (wsize_a[g])
    );
  end

  // Successor of a processor index, wrapping at PROC_COUNT-1.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] v);
    return (v == PW'(PROC_COUNT - 1)) ? '0 : v + PW'(1);
  endfunction

  // Round-robin pick: first requester at or above ptr, wrapping around.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;
    win   = ptr;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < PROC_COUNT; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(PROC_COUNT)) sum = sum - (PW+1)'(PROC_COUNT);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

`ifdef MEM_ARB_RD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`else
  // Keeps the timeout parameter referenced when the feature is compiled out.
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign o_err = 1'b0;
`endif

  // Arbitration FSM; every output is a register, pulses default low each cycle.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= IDLE;
      ptr         <= '0;
      w           <= '0;
      cur_we      <= 1'b0;
      o_grant_rd  <= '0;
      o_grant_wr  <= '0;
      o_valid     <= '0;
      o_data      <= '0;
      o_mem_en    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_wsize <= '0;
`ifdef MEM_ARB_RD_TIMEOUT_EN
      cnt         <= '0;
      o_err       <= 1'b0;
`endif
    end else begin
      o_grant_rd <= '0;
      o_grant_wr <= '0;
      o_valid    <= '0;
      o_mem_en   <= 1'b0;
`ifdef MEM_ARB_RD_TIMEOUT_EN
      o_err      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            // Write wins when a processor asks for both.
            w           <= win;
            cur_we      <= i_req_wr[win];
            o_mem_en    <= 1'b1;
            o_mem_we    <= i_req_wr[win];
            o_mem_addr  <= addr_a[win];
            o_mem_wdata <= wdata_a[win];
            o_mem_wsize <= wsize_a[win];
            if (i_req_wr[win]) o_grant_wr <= PROC_COUNT'(1) << win;
            else               o_grant_rd <= PROC_COUNT'(1) << win;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (cur_we) begin
            ptr   <= nxt(w);
            state <= IDLE;
          end else begin
            state <= RD_WAIT;
`ifdef MEM_ARB_RD_TIMEOUT_EN
            cnt   <= '0;
`endif
          end
        end
        RD_WAIT: begin
          if (i_mem_rvalid) begin
            o_data  <= i_mem_rdata;
            o_valid <= PROC_COUNT'(1) << w;
            ptr     <= nxt(w);
            state   <= IDLE;
          end
`ifdef MEM_ARB_RD_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            // Memory never answered: return poisoned data and flag it.
            o_data  <= '1;
            o_valid <= PROC_COUNT'(1) << w;
            o_err   <= 1'b1;
            ptr     <= nxt(w);
            state   <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (PROC_COUNT=4, BUS_W=64, ADDR_W=16).
module tb_mem_arbiter;
  localparam int P = 4;
  localparam int BW = 64;
  localparam int AW = 16;

  logic              i_clk;
  logic              i_rstn;
  logic [P-1:0]      i_req_rd;
  logic [P-1:0]      i_req_wr;
  logic [P*AW-1:0]   i_addr;
  logic [P*BW-1:0]   i_wr_data;
  logic [P*3-1:0]    i_wr_size;
  logic [P-1:0]      o_grant_rd;
  logic [P-1:0]      o_grant_wr;
  logic [P-1:0]      o_valid;
  logic [BW-1:0]     o_data;
  logic              o_mem_en;
  logic              o_mem_we;
  logic [AW-1:0]     o_mem_addr;
  logic [BW-1:0]     o_mem_wdata;
  logic [2:0]        o_mem_wsize;
  logic [BW-1:0]     i_mem_rdata;
  logic              i_mem_rvalid;
  logic              o_err;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.PROC_COUNT(P), .BUS_W(BW), .ADDR_W(AW), .TIMEOUT(15)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_req_rd(i_req_rd), .i_req_wr(i_req_wr),
    .i_addr(i_addr), .i_wr_data(i_wr_data), .i_wr_size(i_wr_size),
    .o_grant_rd(o_grant_rd), .o_grant_wr(o_grant_wr),
    .o_valid(o_valid), .o_data(o_data),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wsize(o_mem_wsize),
    .i_mem_rdata(i_mem_rdata), .i_mem_rvalid(i_mem_rvalid),
    .o_err(o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".grant_rd"}, 64'(o_grant_rd), 64'h0);
    chk({tag, ".grant_wr"}, 64'(o_grant_wr), 64'h0);
    chk({tag, ".valid"},    64'(o_valid),    64'h0);
    chk({tag, ".data"},     o_data,          64'h0);
    chk({tag, ".mem_en"},   64'(o_mem_en),   64'h0);
    chk({tag, ".mem_addr"}, 64'(o_mem_addr), 64'h0);
    chk({tag, ".err"},      64'(o_err),      64'h0);
  endtask

  initial begin
    int exp_g[9];
    exp_g = '{1, 0, 2, 0, 4, 0, 8, 0, 1};

    i_rstn = 1'b0; i_req_rd = '0; i_req_wr = '0;
    i_addr = '0; i_wr_data = '0; i_wr_size = '0;
    i_mem_rdata = '0; i_mem_rvalid = 1'b0;

    // Reset state, then 20 idle cycles with no memory command.
    #12;
    chk_all_zero("reset");
    tick();
    i_rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle.mem_en", 64'(o_mem_en), 64'h0);
      chk("idle.grant", 64'({o_grant_rd, o_grant_wr}), 64'h0);
    end

    // Proc 2 write.
    i_req_wr[2] = 1'b1;
    i_addr[2*AW +: AW] = 16'h0040;
    i_wr_data[2*BW +: BW] = 64'hA5A5;
    i_wr_size[2*3 +: 3] = 3'd3;
    tick();
    chk("wr.grant_wr", 64'(o_grant_wr), 64'h4);
    chk("wr.grant_rd", 64'(o_grant_rd), 64'h0);
    chk("wr.mem_en", 64'(o_mem_en), 64'h1);
    chk("wr.mem_we", 64'(o_mem_we), 64'h1);
    chk("wr.mem_addr", 64'(o_mem_addr), 64'h40);
    chk("wr.mem_wdata", o_mem_wdata, 64'hA5A5);
    chk("wr.mem_wsize", 64'(o_mem_wsize), 64'h3);
    i_req_wr[2] = 1'b0;
    tick();
    chk("wr.after.mem_en", 64'(o_mem_en), 64'h0);
    chk("wr.after.grant", 64'(o_grant_wr), 64'h0);

    // Proc 1 read, memory answers three cycles after the command.
    i_req_rd[1] = 1'b1;
    i_addr[1*AW +: AW] = 16'h0010;
    tick();
    chk("rd.grant_rd", 64'(o_grant_rd), 64'h2);
    chk("rd.mem_en", 64'(o_mem_en), 64'h1);
    chk("rd.mem_we", 64'(o_mem_we), 64'h0);
    chk("rd.mem_addr", 64'(o_mem_addr), 64'h10);
    i_req_rd[1] = 1'b0;
    tick();
    chk("rd.wait1.valid", 64'(o_valid), 64'h0);
    tick();
    chk("rd.wait2.valid", 64'(o_valid), 64'h0);
    i_mem_rvalid = 1'b1; i_mem_rdata = 64'h1234;
    tick();
    chk("rd.valid", 64'(o_valid), 64'h2);
    chk("rd.data", o_data, 64'h1234);
    i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    tick();
    chk("rd.valid_off", 64'(o_valid), 64'h0);
    chk("rd.data_hold", o_data, 64'h1234);

    // Stray rvalid while idle is ignored.
    i_mem_rvalid = 1'b1; i_mem_rdata = 64'hDEAD;
    tick();
    i_mem_rvalid = 1'b0;
    chk("stray.valid", 64'(o_valid), 64'h0);
    chk("stray.data", o_data, 64'h1234);

    // All four write continuously from reset: strict rotation, one per 2 cycles.
    i_rstn = 1'b0; #2; i_rstn = 1'b1;
    for (int p = 0; p < P; p++) i_addr[p*AW +: AW] = AW'(16'h0100 + p);
    i_req_wr = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("rr.grant%0d", i), 64'(o_grant_wr), 64'(exp_g[i]));
      chk($sformatf("rr.en%0d", i), 64'(o_mem_en), 64'(exp_g[i] != 0));
      if (exp_g[i] != 0)
        chk($sformatf("rr.addr%0d", i), 64'(o_mem_addr), 64'(16'h0100 + $clog2(exp_g[i])));
    end
    i_req_wr = '0;
    tick();

    // Proc 0 asks for both: write first, then read.
    i_req_rd[0] = 1'b1; i_req_wr[0] = 1'b1;
    tick();
    chk("both.grant_wr", 64'(o_grant_wr), 64'h1);
    chk("both.grant_rd0", 64'(o_grant_rd), 64'h0);
    i_req_wr[0] = 1'b0;
    tick();
    tick();
    chk("both.grant_rd", 64'(o_grant_rd), 64'h1);
    i_req_rd[0] = 1'b0;
    tick();
    i_mem_rvalid = 1'b1; i_mem_rdata = 64'hCAFE;
    tick();
    chk("both.valid", 64'(o_valid), 64'h1);
    chk("both.data", o_data, 64'hCAFE);
    i_mem_rvalid = 1'b0;

    // Proc 3 read abandoned by reset; its late rvalid is ignored.
    i_req_rd[3] = 1'b1;
    tick();
    chk("rst.grant_rd", 64'(o_grant_rd), 64'h8);
    i_req_rd[3] = 1'b0;
    tick();
    i_rstn = 1'b0;
    #1;
    chk_all_zero("rst.mid");
    tick();
    i_rstn = 1'b1;
    i_mem_rvalid = 1'b1; i_mem_rdata = 64'hBEEF;
    tick();
    i_mem_rvalid = 1'b0;
    chk("rst.late.valid", 64'(o_valid), 64'h0);
    chk("rst.late.data", o_data, 64'h0);
    i_req_wr = 4'b1100; i_req_rd = 4'b0001;
    tick();
    chk("rst.next.grant_rd", 64'(o_grant_rd), 64'h1);
    chk("rst.next.grant_wr", 64'(o_grant_wr), 64'h0);
    i_req_wr = '0; i_req_rd = '0;
    tick();
    tick();
    i_mem_rvalid = 1'b1; i_mem_rdata = 64'h77;
    tick();
    i_mem_rvalid = 1'b0;
    chk("rst.next.valid", 64'(o_valid), 64'h1);

`ifdef MEM_ARB_RD_TIMEOUT_EN
    // Read with no response: 15 cycles in RD_WAIT, then poisoned completion.
    i_req_rd[2] = 1'b1;
    tick();
    chk("to.grant_rd", 64'(o_grant_rd), 64'h4);
    i_req_rd[2] = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("to.wait%0d.valid", i), 64'(o_valid), 64'h0);
      chk($sformatf("to.wait%0d.err", i), 64'(o_err), 64'h0);
      tick();
    end
    chk("to.valid", 64'(o_valid), 64'h4);
    chk("to.data", o_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("to.err", 64'(o_err), 64'h1);
    tick();
    chk("to.valid_off", 64'(o_valid), 64'h0);
    chk("to.err_off", 64'(o_err), 64'h0);
`else
    // Without the timeout a read waits as long as memory takes.
    i_req_rd[2] = 1'b1;
    tick();
    chk("nto.grant_rd", 64'(o_grant_rd), 64'h4);
    i_req_rd[2] = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      chk($sformatf("nto.wait%0d", i), 64'({o_valid, o_err}), 64'h0);
    end
    i_mem_rvalid = 1'b1; i_mem_rdata = 64'h55;
    tick();
    i_mem_rvalid = 1'b0;
    chk("nto.valid", 64'(o_valid), 64'h4);
    chk("nto.data", o_data, 64'h55);
    chk("nto.err", 64'(o_err), 64'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Memory-side responder for the processor pool's read/write request interface.
- Accepts per-processor read/write requests and round-robin arbitrates them onto a single memory port.
- Returns per-processor grant pulses and a one-cycle valid for read data on a shared broadcast data bus.
- Sits between the processor pool and the shared data memory; its outputs feed the pool's grant, valid and data inputs.

Parameters:
- PROC_COUNT, 4, number of requesting processors.
- BUS_W, 64, data bus width in bits.
- ADDR_W, 16, address width in bits.
- TIMEOUT, 15, read timeout in cycles (used only with the optional feature).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_req_rd  in  PROC_COUNT  per-processor read request, level, held until granted.
- i_req_wr  in  PROC_COUNT  per-processor write request, level, held until granted.
- i_addr  in  PROC_COUNT*ADDR_W  per-processor address; slice i belongs to processor i.
- i_wr_data  in  PROC_COUNT*BUS_W  per-processor write data.
- i_wr_size  in  PROC_COUNT*3  per-processor write size code, passed through unchanged.
- o_grant_rd  out  PROC_COUNT  one-hot, one-cycle read grant.
- o_grant_wr  out  PROC_COUNT  one-hot, one-cycle write grant.
- o_valid  out  PROC_COUNT  one-hot, one-cycle read-data valid.
- o_data  out  BUS_W  broadcast read data; meaningful only while o_valid is nonzero.
- o_mem_en  out  1  memory command strobe, one cycle.
- o_mem_we  out  1  1 = write command, 0 = read command.
- o_mem_addr  out  ADDR_W  memory address.
- o_mem_wdata  out  BUS_W  memory write data.
- o_mem_wsize  out  3  memory write size code.
- i_mem_rdata  in  BUS_W  memory read data.
- i_mem_rvalid  in  1  memory read data valid.
- o_err  out  1  read-timeout pulse (optional feature only; tied 0 otherwise).

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; state IDLE; round-robin pointer ptr = 0.
- FSM has three states: IDLE, GRANT, RD_WAIT.
- IDLE:
  - Compute req = i_req_rd | i_req_wr.
  - If req is nonzero, winner w is the first set bit scanning upward from ptr, wrapping at PROC_COUNT-1 back to 0.
  - Latch w, addr[w], wr_data[w] and wr_size[w].
  - Operation is a write if i_req_wr[w] = 1; a processor asserting both rd and wr gets the write first.
  - Go to GRANT.
- GRANT (exactly one cycle):
  - Assert o_grant_wr[w] or o_grant_rd[w], together with o_mem_en = 1, o_mem_we and the latched addr/data/size.
  - Write: ptr <= (w+1) mod PROC_COUNT; go to IDLE.
  - Read: go to RD_WAIT.
- RD_WAIT:
  - On i_mem_rvalid = 1: o_data <= i_mem_rdata, o_valid[w] <= 1 for one cycle; ptr <= (w+1) mod PROC_COUNT; go to IDLE.
  - o_data holds its value until the next read response.
- Latency:
  - Request sampled in IDLE at cycle N gives grant and memory command at N+1.
  - i_mem_rvalid at cycle M gives o_valid at M+1.
  - Write throughput: one per 2 cycles. Read throughput: one per (3 + memory latency) cycles.
- Boundary conditions:
  - i_mem_rvalid outside RD_WAIT is ignored.
  - A request deasserted after latching does not cancel the transaction.
  - New requests arriving in GRANT or RD_WAIT wait for the next IDLE.
  - No two grant or valid bits are ever high in the same cycle.
  - ptr wraps from PROC_COUNT-1 to 0.
  - A single persistent requester is served every transaction; no starvation, since each processor waits at most PROC_COUNT-1 transactions.
  - Reset mid-operation: outputs clear immediately; an outstanding read is abandoned and its later rvalid is ignored (FSM is in IDLE).

Optional Feature:
- Macro: MEM_ARB_RD_TIMEOUT_EN.
- Defined:
  - A counter runs in RD_WAIT.
  - If i_mem_rvalid has not arrived after TIMEOUT cycles, assert o_valid[w] = 1 with o_data = all ones and o_err = 1, each for one cycle.
  - Advance ptr and return to IDLE.
  - The counter resets on every entry to RD_WAIT.
- Undefined: no counter; RD_WAIT waits indefinitely; o_err is constant 0.

Test Plan:
- Reset then idle: all outputs 0, ptr = 0, no o_mem_en for 20 cycles.
- Proc 2 write, addr 0x0040, data 0xA5A5, size 3 → next cycle o_grant_wr = 0100, o_mem_en = 1, o_mem_we = 1, o_mem_addr = 0x0040, o_mem_wdata = 0xA5A5, o_mem_wsize = 3; back in IDLE the cycle after.
- Proc 1 read, addr 0x0010; memory returns 0x1234 three cycles after o_mem_en → o_grant_rd = 0010, then o_valid = 0010 with o_data = 0x1234 one cycle after rvalid.
- All 4 procs request writes continuously from reset → grants in order 0001, 0010, 0100, 1000, 0001, one every 2 cycles.
- Proc 3 read outstanding, i_rstn pulsed low, then rvalid → outputs 0 during reset; no o_valid afterwards; next request goes to proc 0 first.
- With MEM_ARB_RD_TIMEOUT_EN, TIMEOUT = 15: read with no rvalid → exactly 15 cycles in RD_WAIT, then o_valid[w] = 1, o_data = all ones, o_err = 1, each for one cycle.
